display_arbiter: RTL

//  Shares the six-digit HEX display and 4-bit LED bank between the password-entry source, the lock FSM and a timed alert overlay.

---
 rtl/display_arbiter_if.sv | 40 ++++
 rtl/display_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter_if.sv
// display_arbiter_if
//   Bundles the source-side request/data signals and the arbiter's
//   grant/display outputs for the display arbiter.
//   slave  : arbiter side (takes requests and data, drives grants/display)
//   master : source side (drives requests and data, observes grants/display)
//   Signals:
//     pw_req, pw_digits[11:0], pw_led[3:0]       password source
//     fsm_req, fsm_digits[23:0], fsm_led[3:0]    lock FSM source
//     alert_req, alert_digits[23:0]              alert overlay strobe + message
//     pw_gnt, fsm_gnt                            ownership grants
//     disp_codes[23:0], led[3:0], busy           display drive and status
interface display_arbiter_if;
    logic        pw_req;
    logic [11:0] pw_digits;
    logic [3:0]  pw_led;
    logic        fsm_req;
    logic [23:0] fsm_digits;
    logic [3:0]  fsm_led;
    logic        alert_req;
    logic [23:0] alert_digits;
    logic        pw_gnt;
    logic        fsm_gnt;
    logic [23:0] disp_codes;
    logic [3:0]  led;
    logic        busy;

    modport slave (
        input  pw_req, pw_digits, pw_led,
        input  fsm_req, fsm_digits, fsm_led,
        input  alert_req, alert_digits,
        output pw_gnt, fsm_gnt, disp_codes, led, busy
    );

    modport master (
        output pw_req, pw_digits, pw_led,
        output fsm_req, fsm_digits, fsm_led,
        output alert_req, alert_digits,
        input  pw_gnt, fsm_gnt, disp_codes, led, busy
    );
endinterface

// File: rtl/display_arbiter.sv
// display_arbiter
//   Shares the six-digit HEX display and the 4-bit LED bank between the
//   password-entry source, the lock FSM and a blinking alert overlay.
//   Emits raw 4-bit symbol codes for the downstream 7-segment encoder.
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset (released synchronously upstream)
//     bus      display_arbiter_if.slave: requests/data in, grants/display out
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | nobody owns the display, all digits blank
//   PW        | password source owns the display (HEX0..HEX2)
//   FSM       | lock FSM owns the display (HEX0..HEX5)
//   ALERT_ON  | alert message shown, all LEDs lit
//   ALERT_OFF | alert blink gap, display blank, LEDs off
module display_arbiter #(
    parameter int          HOLD_CYCLES  = 50_000_000,
    parameter int          BLINK_CYCLES = 12_500_000,
    parameter int          ALERT_BLINKS = 3,
    parameter logic [3:0]  EMPTY_CODE   = 4'd15
) (
    input  logic             clk,
    input  logic             reset_n,
    display_arbiter_if.slave bus
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam int PAIR_W  = $clog2(ALERT_BLINKS + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [PAIR_W-1:0]  PAIR_LOAD  = PAIR_W'(ALERT_BLINKS - 1);
    localparam logic [23:0]        BLANK      = {6{EMPTY_CODE}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PW        = 3'd1,
        FSM       = 3'd2,
        ALERT_ON  = 3'd3,
        ALERT_OFF = 3'd4
    } state_t;

    state_t               state, state_nx, arb_st;
    logic [HOLD_W-1:0]    hold_cnt, hold_nx;
    logic [BLINK_W-1:0]   blink_cnt, blink_nx;
    logic [PAIR_W-1:0]    pair_cnt, pair_nx;
    logic                 alert_pend, pend_nx;
    logic [23:0]          alert_buf;

    logic [23:0]          codes_nx;
    logic [3:0]           led_nx;
    logic                 pw_gnt_nx, fsm_gnt_nx, busy_nx;

    // Fresh arbitration, used from IDLE and at the end of an alert.
    always_comb begin
        arb_st = IDLE;
        if (alert_pend)
            arb_st = ALERT_ON;
        else if (bus.pw_req)
            arb_st = PW;
        else if (bus.fsm_req)
            arb_st = FSM;
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        blink_nx = blink_cnt;
        pair_nx  = pair_cnt;
        pend_nx  = alert_pend;

        case (state)
            IDLE: state_nx = arb_st;
            PW: begin
                if (hold_cnt != '0)
                    hold_nx = hold_cnt - HOLD_W'(1);
                else if (!bus.pw_req)
                    state_nx = bus.fsm_req ? FSM : IDLE;
            end
            FSM: begin
                if (hold_cnt != '0)
                    hold_nx = hold_cnt - HOLD_W'(1);
                else if (!bus.fsm_req || bus.pw_req)
                    state_nx = bus.pw_req ? PW : IDLE;
            end
            ALERT_ON: begin
                if (blink_cnt == '0) begin
                    state_nx = ALERT_OFF;
                    blink_nx = BLINK_LOAD;
                end else begin
                    blink_nx = blink_cnt - BLINK_W'(1);
                end
            end
            ALERT_OFF: begin
                if (blink_cnt == '0) begin
                    if (pair_cnt == '0) begin
                        state_nx = arb_st;
                    end else begin
                        state_nx = ALERT_ON;
                        blink_nx = BLINK_LOAD;
                        pair_nx  = pair_cnt - PAIR_W'(1);
                    end
                end else begin
                    blink_nx = blink_cnt - BLINK_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        // A pending alert overrides whatever the owner would do, hold or not,
        // and restarts the blink sequence from the top.
        if (alert_pend) begin
            state_nx = ALERT_ON;
            blink_nx = BLINK_LOAD;
            pair_nx  = PAIR_LOAD;
            pend_nx  = 1'b0;
        end

        if ((state_nx == PW || state_nx == FSM) && state_nx != state)
            hold_nx = HOLD_LOAD;

        // A new strobe on the same edge as alert entry must win over the clear.
        if (bus.alert_req)
            pend_nx = 1'b1;
    end

    // Outputs are decoded from the next state so grant and display switch on
    // the same edge as the state, carrying the owner's inputs one cycle late.
    always_comb begin
        codes_nx   = BLANK;
        led_nx     = 4'h0;
        pw_gnt_nx  = 1'b0;
        fsm_gnt_nx = 1'b0;
        busy_nx    = (state_nx != IDLE);
        case (state_nx)
            PW: begin
                codes_nx  = {BLANK[23:12], bus.pw_digits};
                led_nx    = bus.pw_led;
                pw_gnt_nx = 1'b1;
            end
            FSM: begin
                codes_nx   = bus.fsm_digits;
                led_nx     = bus.fsm_led;
                fsm_gnt_nx = 1'b1;
            end
            ALERT_ON: begin
                codes_nx = alert_buf;
                led_nx   = 4'hF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            hold_cnt       <= '0;
            blink_cnt      <= '0;
            pair_cnt       <= '0;
            alert_pend     <= 1'b0;
            alert_buf      <= BLANK;
            bus.disp_codes <= BLANK;
            bus.led        <= 4'h0;
            bus.pw_gnt     <= 1'b0;
            bus.fsm_gnt    <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_nx;
            hold_cnt       <= hold_nx;
            blink_cnt      <= blink_nx;
            pair_cnt       <= pair_nx;
            alert_pend     <= pend_nx;
            if (bus.alert_req)
                alert_buf  <= bus.alert_digits;
            bus.disp_codes <= codes_nx;
            bus.led        <= led_nx;
            bus.pw_gnt     <= pw_gnt_nx;
            bus.fsm_gnt    <= fsm_gnt_nx;
            bus.busy       <= busy_nx;
        end
    end

endmodule
